// File: rtl/pc_branch_pkg.sv
// Shared types and default widths for the PC / branch unit.
package pc_branch_pkg;

  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_PC_W        = 32;
  localparam int unsigned DEF_OFF_W       = 19;
  localparam int unsigned DEF_STACK_DEPTH = 4;

  // C2 field of the conditional-branch instruction
  typedef enum logic [1:0] {
    COND_ZERO = 2'b00,
    COND_NZ   = 2'b01,
    COND_POS  = 2'b10,
    COND_NEG  = 2'b11
  } cond_e;

  // Winning PC operation after strobe priority resolution
  typedef enum logic [2:0] {
    PC_OP_HOLD   = 3'd0,
    PC_OP_LOAD   = 3'd1,
    PC_OP_CALL   = 3'd2,
    PC_OP_RET    = 3'd3,
    PC_OP_BRANCH = 3'd4,
    PC_OP_INC    = 3'd5
  } pc_op_e;

endpackage

// File: rtl/pc_branch_unit_link_stack.sv
// Call/return link stack: LIFO of return PCs with sticky overflow/underflow flag.
module link_stack
  import pc_branch_pkg::*;
#(
  parameter int unsigned PC_W        = DEF_PC_W,
  parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top_data,
  output logic            full,
  output logic            empty,
  output logic            err
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_W-1:0]  r_mem [STACK_DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic             r_err;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_top_idx;
  logic             w_full;
  logic             w_empty;

  assign w_full    = (r_ptr == PTR_W'(STACK_DEPTH));
  assign w_empty   = (r_ptr == '0);
  assign w_wr_idx  = IDX_W'(r_ptr);
  assign w_top_idx = IDX_W'(r_ptr - PTR_W'(1));

  assign top_data = r_mem[w_top_idx];
  assign full     = w_full;
  assign empty    = w_empty;
  assign err      = r_err;

  // pointer and sticky error; push wins over pop, clr discards both
  always_ff @(posedge clk) begin
    if (clr) begin
      r_ptr <= '0;
      r_err <= 1'b0;
    end else if (push) begin
      if (w_full) r_err <= 1'b1;
      else        r_ptr <= r_ptr + PTR_W'(1);
    end else if (pop) begin
      if (w_empty) r_err <= 1'b1;
      else         r_ptr <= r_ptr - PTR_W'(1);
    end
  end

  // entry storage; contents need no reset
  always_ff @(posedge clk) begin
    if (!clr && push && !w_full) r_mem[w_wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter, registered branch condition and call/return link stack.
module pc_branch_unit
  import pc_branch_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned PC_W        = DEF_PC_W,
  parameter int unsigned OFF_W       = DEF_OFF_W,
  parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              incPC,
  input  logic              PCins,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              CONin,
  input  logic [1:0]        cond_sel,
  input  logic [DATA_W-1:0] rdata,
  input  logic              br_take,
  input  logic [OFF_W-1:0]  offset,
  input  logic              call,
  input  logic              ret,
  output logic [PC_W-1:0]   PC,
  output logic              CON,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              stack_err
);

  logic [PC_W-1:0] r_pc;
  logic            r_con;
  pc_op_e          w_op;
  logic            w_cond;
  logic [PC_W-1:0] w_bus_pc;
  logic [PC_W-1:0] w_off_ext;
  logic [PC_W-1:0] w_top;
  logic            w_full;
  logic            w_empty;
  logic            w_err;

  assign w_bus_pc  = bus_in[PC_W-1:0];
  assign w_off_ext = PC_W'($signed(offset));

  // condition test on the tested register
  always_comb begin
    w_cond = 1'b0;
    unique case (cond_e'(cond_sel))
      COND_ZERO: w_cond = (rdata == '0);
      COND_NZ:   w_cond = (rdata != '0);
      COND_POS:  w_cond = !rdata[DATA_W-1] && (rdata != '0);
      COND_NEG:  w_cond = rdata[DATA_W-1];
      default:   w_cond = 1'b0;
    endcase
  end

  // strobe priority; a not-taken branch falls through to incPC
  always_comb begin
    w_op = PC_OP_HOLD;
    if (PCins)                w_op = PC_OP_LOAD;
    else if (call)            w_op = PC_OP_CALL;
    else if (ret)             w_op = PC_OP_RET;
    else if (br_take && r_con) w_op = PC_OP_BRANCH;
    else if (incPC)           w_op = PC_OP_INC;
  end

  link_stack #(
    .PC_W       (PC_W),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_link_stack (
    .clk      (clk),
    .clr      (clr),
    .push     (w_op == PC_OP_CALL),
    .pop      (w_op == PC_OP_RET),
    .push_data(r_pc),
    .top_data (w_top),
    .full     (w_full),
    .empty    (w_empty),
    .err      (w_err)
  );

  // PC register; failed call/ret leave PC unchanged
  always_ff @(posedge clk) begin
    if (clr) begin
      r_pc <= '0;
    end else begin
      case (w_op)
        PC_OP_LOAD:   r_pc <= w_bus_pc;
        PC_OP_CALL:   if (!w_full)  r_pc <= w_bus_pc;
        PC_OP_RET:    if (!w_empty) r_pc <= w_top;
        PC_OP_BRANCH: r_pc <= r_pc + w_off_ext;
        PC_OP_INC:    r_pc <= r_pc + PC_W'(1);
        default:      r_pc <= r_pc;
      endcase
    end
  end

  // CON flag, loaded only on CONin
  always_ff @(posedge clk) begin
    if (clr)        r_con <= 1'b0;
    else if (CONin) r_con <= w_cond;
  end

  assign PC          = r_pc;
  assign CON         = r_con;
  assign stack_empty = w_empty;
  assign stack_full  = w_full;
  assign stack_err   = w_err;

endmodule

// File: tb/tb_pc_branch_unit.sv
module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        clr, incPC, PCins, CONin, br_take, call, ret;
  logic [31:0] bus_in, rdata;
  logic [1:0]  cond_sel;
  logic [18:0] offset;
  logic [31:0] PC;
  logic        CON, stack_empty, stack_full, stack_err;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // behavioural model
  logic [31:0] m_pc;
  bit          m_con;
  bit          m_err;
  logic [31:0] m_stk[$];

  always #5 clk = ~clk;

  pc_branch_unit #(
    .DATA_W(32), .PC_W(32), .OFF_W(19), .STACK_DEPTH(4)
  ) dut (
    .clk(clk), .clr(clr), .incPC(incPC), .PCins(PCins), .bus_in(bus_in),
    .CONin(CONin), .cond_sel(cond_sel), .rdata(rdata), .br_take(br_take),
    .offset(offset), .call(call), .ret(ret), .PC(PC), .CON(CON),
    .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit eval_cond(input logic [1:0] sel, input logic [31:0] v);
    case (sel)
      2'd0:    return v == 0;
      2'd1:    return v != 0;
      2'd2:    return $signed(v) > 0;
      default: return $signed(v) < 0;
    endcase
  endfunction

  // model update from the rules: priority chain, queue as the link stack
  always @(posedge clk) begin
    bit new_con;
    new_con = CONin ? eval_cond(cond_sel, rdata) : m_con;
    if (clr) begin
      m_pc = 0; new_con = 0; m_err = 0; m_stk.delete();
    end else if (PCins) begin
      m_pc = bus_in;
    end else if (call) begin
      if (m_stk.size() == 4) m_err = 1;
      else begin m_stk.push_back(m_pc); m_pc = bus_in; end
    end else if (ret) begin
      if (m_stk.size() == 0) m_err = 1;
      else m_pc = m_stk.pop_back();
    end else if (br_take && m_con) begin
      m_pc = m_pc + 32'($signed(offset));
    end else if (incPC) begin
      m_pc = m_pc + 1;
    end
    m_con = new_con;
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_pc",    PC,          m_pc);
      chk("model_con",   32'(CON),    32'(m_con));
      chk("model_empty", 32'(stack_empty), 32'(m_stk.size() == 0));
      chk("model_full",  32'(stack_full),  32'(m_stk.size() == 4));
      chk("model_err",   32'(stack_err),   32'(m_err));
    end
  end

  task automatic idle();
    clr = 0; incPC = 0; PCins = 0; CONin = 0; br_take = 0; call = 0; ret = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    idle();
  endtask

  task automatic load_pc(input logic [31:0] v);
    PCins = 1; bus_in = v; tick();
  endtask

  task automatic do_call(input logic [31:0] tgt);
    call = 1; bus_in = tgt; tick();
  endtask

  initial begin
    logic [31:0] rets [4];
    rets = '{32'h300, 32'h200, 32'h100, 32'h1};
    idle();
    bus_in = 0; rdata = 0; cond_sel = 0; offset = 0;
    clr = 1; tick();
    cmp_en = 1;
    chk("rst_pc", PC, 0);
    chk("rst_con", 32'(CON), 0);
    chk("rst_empty", 32'(stack_empty), 1);
    chk("rst_full", 32'(stack_full), 0);
    chk("rst_err", 32'(stack_err), 0);

    // positive test, branch forward
    load_pc(32'h10);
    rdata = 32'h12; cond_sel = 2'b10; CONin = 1; tick();
    chk("con_pos", 32'(CON), 1);
    offset = 19'h1FF; br_take = 1; tick();
    chk("br_fwd", PC, 32'h20F);

    // zero test false: branch not taken, then falls through to incPC
    rdata = 32'h22; cond_sel = 2'b00; CONin = 1; tick();
    chk("con_zero_false", 32'(CON), 0);
    br_take = 1; tick();
    chk("br_not_taken", PC, 32'h20F);
    br_take = 1; incPC = 1; tick();
    chk("br_nt_inc", PC, 32'h210);

    // negative test, backward branch wrapping below zero, then incPC wrap
    load_pc(32'h5);
    rdata = 32'h8000_0000; cond_sel = 2'b11; CONin = 1; tick();
    chk("con_neg", 32'(CON), 1);
    offset = 19'h7FFFA; br_take = 1; tick();
    chk("br_wrap", PC, 32'hFFFF_FFFF);
    incPC = 1; tick();
    chk("inc_wrap", PC, 0);

    // CONin and br_take together: branch uses old CON
    rdata = 0; cond_sel = 2'b01; CONin = 1; offset = 19'h2; br_take = 1; tick();
    chk("br_old_con_pc", PC, 2);
    chk("br_old_con_flag", 32'(CON), 0);
    // positive test must reject zero
    rdata = 0; cond_sel = 2'b10; CONin = 1; tick();
    chk("con_pos_zero", 32'(CON), 0);

    // fill the link stack
    load_pc(32'h1);
    do_call(32'h100);
    do_call(32'h200);
    do_call(32'h300);
    do_call(32'h400);
    chk("call_pc", PC, 32'h400);
    chk("full_set", 32'(stack_full), 1);
    do_call(32'h500);
    chk("overflow_pc", PC, 32'h400);
    chk("overflow_err", 32'(stack_err), 1);
    for (int i = 0; i < 4; i++) begin
      ret = 1; tick();
      chk("ret_pc", PC, rets[i]);
    end
    chk("ret_empty", 32'(stack_empty), 1);

    // underflow on a cleared unit, then a three-way collision
    clr = 1; tick();
    ret = 1; tick();
    chk("underflow_pc", PC, 0);
    chk("underflow_err", 32'(stack_err), 1);
    call = 1; ret = 1; PCins = 1; bus_in = 32'h44; tick();
    chk("pcins_wins", PC, 32'h44);
    chk("pcins_stack", 32'(stack_empty), 1);

    // call beats ret in the same cycle
    do_call(32'h60);
    call = 1; ret = 1; bus_in = 32'h70; tick();
    chk("call_over_ret", PC, 32'h70);

    // clr during a call sequence
    clr = 1; tick();
    do_call(32'h80);
    do_call(32'h90);
    clr = 1; call = 1; bus_in = 32'hA0; tick();
    chk("clr_pc", PC, 0);
    chk("clr_con", 32'(CON), 0);
    chk("clr_empty", 32'(stack_empty), 1);
    chk("clr_err", 32'(stack_err), 0);
    ret = 1; tick();
    chk("post_clr_err", 32'(stack_err), 1);
    chk("post_clr_pc", PC, 0);

    tick();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
